// File: rtl/spi_master_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_master_ctrl                                                          |
// | Single-frame SPI master: CPOL/CPHA, MSB/LSB order, programmable SCLK.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module spi_master_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int DIV_WIDTH  = 8
) (
   input  logic                  pclk,
   input  logic                  areset,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  cpol,
   input  logic                  cpha,
   input  logic                  lsb_first,
   input  logic [DIV_WIDTH-1:0]  clk_div,
   output logic                  rx_valid,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  busy,
   output logic                  sclk,
   output logic                  cs,
   output logic                  mosi0,
   input  logic                  miso0
);

   localparam int c_edge_w = $clog2(2 * DATA_WIDTH);
   localparam int c_bit_w  = c_edge_w - 1;
   localparam logic [c_edge_w-1:0] c_last_edge = c_edge_w'(2 * DATA_WIDTH - 1);
   localparam logic [c_bit_w-1:0]  c_last_bit  = c_bit_w'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEAD  = 3'd1,
      S_XFER  = 3'd2,
      S_TRAIL = 3'd3,
      S_GAP   = 3'd4
   } state_t;

   state_t                r_state;
   logic [DIV_WIDTH-1:0]  r_hcnt;
   logic [DIV_WIDTH-1:0]  r_div;
   logic [c_edge_w-1:0]   r_edge;
   logic                  r_cpha;
   logic                  r_lsb;
   logic [DATA_WIDTH-1:0] r_tx;
   logic [DATA_WIDTH-1:0] r_rx;

   logic                  w_hdone;
   logic                  w_do_edge;
   logic [c_edge_w-1:0]   w_edge;
   logic [c_bit_w-1:0]    w_bit;
   logic                  w_sample;
   logic                  w_mosi_upd;
   logic [c_bit_w-1:0]    w_mosi_bit;

   function automatic logic [c_bit_w-1:0] bit_pos(input logic [c_bit_w-1:0] k,
                                                  input logic lsb);
      return lsb ? k : c_last_bit - k;
   endfunction

   // Edge 0 fires on leaving LEAD; the remaining edges fire once per half-period in XFER.
   assign w_hdone    = (r_hcnt == '0);
   assign w_do_edge  = w_hdone && ((r_state == S_LEAD) ||
                                   ((r_state == S_XFER) && (r_edge != c_last_edge)));
   assign w_edge     = (r_state == S_LEAD) ? '0 : r_edge + 1'b1;
   assign w_bit      = w_edge[c_edge_w-1:1];
   assign w_sample   = (w_edge[0] == r_cpha);
   assign w_mosi_upd = r_cpha ? !w_edge[0] : (w_edge[0] && (w_bit != c_last_bit));
   assign w_mosi_bit = r_cpha ? w_bit : w_bit + 1'b1;

   assign tx_ready = (r_state == S_IDLE) && !areset;
   assign busy     = (r_state != S_IDLE);

   always_ff @(posedge pclk) begin
      if (areset) begin
         r_state  <= S_IDLE;
         r_hcnt   <= '0;
         r_div    <= '0;
         r_edge   <= '0;
         r_cpha   <= 1'b0;
         r_lsb    <= 1'b0;
         r_tx     <= '0;
         r_rx     <= '0;
         sclk     <= 1'b0;
         cs       <= 1'b1;
         mosi0    <= 1'b0;
         rx_valid <= 1'b0;
         rx_data  <= '0;
      end else begin
         rx_valid <= 1'b0;

         if (r_state != S_IDLE) begin
            r_hcnt <= w_hdone ? r_div : r_hcnt - 1'b1;
         end

         if (w_do_edge) begin
            r_edge <= w_edge;
            sclk   <= ~sclk;
            if (w_sample) begin
               r_rx[bit_pos(w_bit, r_lsb)] <= miso0;
            end
            if (w_mosi_upd) begin
               mosi0 <= r_tx[bit_pos(w_mosi_bit, r_lsb)];
            end
         end

         case (r_state)
            S_IDLE: begin
               sclk  <= cpol;
               cs    <= 1'b1;
               mosi0 <= 1'b0;
               if (tx_valid) begin
                  r_tx    <= tx_data;
                  r_cpha  <= cpha;
                  r_lsb   <= lsb_first;
                  r_div   <= clk_div;
                  r_hcnt  <= clk_div;
                  cs      <= 1'b0;
                  mosi0   <= cpha ? 1'b0
                                  : (lsb_first ? tx_data[0] : tx_data[DATA_WIDTH-1]);
                  r_state <= S_LEAD;
               end
            end
            S_LEAD: begin
               if (w_hdone) r_state <= S_XFER;
            end
            S_XFER: begin
               if (w_hdone && (r_edge == c_last_edge)) r_state <= S_TRAIL;
            end
            S_TRAIL: begin
               if (w_hdone) begin
                  cs       <= 1'b1;
                  mosi0    <= 1'b0;
                  rx_valid <= 1'b1;
                  rx_data  <= r_rx;
                  r_state  <= S_GAP;
               end
            end
            S_GAP: begin
               if (w_hdone) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spi_master_ctrl                                                       |
// | Randomized frames against an SPI slave model with arithmetic timing.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_spi_master_ctrl;

   localparam int DW = 8;

   logic          pclk;
   logic          areset;
   logic          tx_valid;
   logic          tx_ready;
   logic [DW-1:0] tx_data;
   logic          cpol;
   logic          cpha;
   logic          lsb_first;
   logic [7:0]    clk_div;
   logic          rx_valid;
   logic [DW-1:0] rx_data;
   logic          busy;
   logic          sclk;
   logic          cs;
   logic          mosi0;
   logic          miso0;

   int n_checks = 0;
   int n_errors = 0;

   spi_master_ctrl #(.DATA_WIDTH(DW), .DIV_WIDTH(8)) dut (
      .pclk      (pclk),
      .areset    (areset),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .tx_data   (tx_data),
      .cpol      (cpol),
      .cpha      (cpha),
      .lsb_first (lsb_first),
      .clk_div   (clk_div),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .busy      (busy),
      .sclk      (sclk),
      .cs        (cs),
      .mosi0     (mosi0),
      .miso0     (miso0)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // One frame seen from the pins; the slave side shifts miso_w out and collects mosi0.
   task automatic run_frame(input logic [DW-1:0] data, input logic pol, input logic pha,
                            input logic lsb, input logic [7:0] div, input logic [DW-1:0] miso_w,
                            input bit hold, input logic [DW-1:0] next_data,
                            input bit scramble, input int abort_bits);
      int            h;
      int            limit;
      int            len;
      int            nsamp;
      int            nedge;
      int            cs_low;
      int            gap;
      int            npulse;
      int            pulse_cyc;
      int            ready_bad;
      int            rx_changes;
      bit            done;
      bit            lead;
      logic          prev_sclk;
      logic          first_sclk;
      logic          first_cs;
      logic          first_mosi;
      logic [DW-1:0] mosi_w;
      logic [DW-1:0] got_rx;
      logic [DW-1:0] prev_rx;

      h     = int'(div) + 1;
      limit = (2 * DW + 3) * h + 20;

      tx_valid  = 1'b1;
      tx_data   = data;
      cpol      = pol;
      cpha      = pha;
      lsb_first = lsb;
      clk_div   = div;
      miso0     = lsb ? miso_w[0] : miso_w[DW-1];
      #1;
      check_eq("ready_idle", tx_ready, 1);
      prev_rx = rx_data;
      @(posedge pclk);
      @(negedge pclk);
      if (hold) tx_data = next_data;
      else      tx_valid = 1'b0;

      prev_sclk  = pol;
      first_sclk = sclk;
      first_cs   = cs;
      first_mosi = mosi0;
      nsamp = 0; nedge = 0; cs_low = 0; gap = 0; npulse = 0; pulse_cyc = -1;
      ready_bad = 0; rx_changes = 0; len = -1; done = 1'b0;
      mosi_w = '0; got_rx = '0;

      for (int cyc = 0; cyc < limit && !done; cyc++) begin
         if (cyc > 0) @(negedge pclk);
         if (!busy) begin
            done = 1'b1;
            len  = cyc;
            if (cs) gap++;
         end else begin
            if (tx_ready) ready_bad++;
            if (!cs) cs_low++;
            else     gap++;
            if (sclk != prev_sclk) begin
               nedge++;
               lead = (sclk != pol);
               if (lead == !pha) begin
                  if (nsamp < DW) mosi_w[lsb ? nsamp : DW - 1 - nsamp] = mosi0;
                  nsamp++;
                  if (nsamp < DW) miso0 = miso_w[lsb ? nsamp : DW - 1 - nsamp];
                  if (abort_bits != 0 && nsamp == abort_bits) begin
                     areset = 1'b1;
                     @(negedge pclk);
                     check_eq("abort_cs", cs, 1);
                     check_eq("abort_sclk", sclk, 0);
                     check_eq("abort_rx_valid", rx_valid, 0);
                     check_eq("abort_rx_data", rx_data, 0);
                     check_eq("abort_busy", busy, 0);
                     check_eq("abort_ready", tx_ready, 0);
                     areset   = 1'b0;
                     tx_valid = 1'b0;
                     #1;
                     check_eq("abort_ready_rise", tx_ready, 1);
                     return;
                  end
               end
               prev_sclk = sclk;
            end
            if (rx_valid) begin
               npulse++;
               pulse_cyc = cyc;
               got_rx    = rx_data;
               prev_rx   = rx_data;
            end else if (rx_data != prev_rx) begin
               rx_changes++;
            end
            if (scramble && nedge == 3) begin
               cpol      = ~pol;
               cpha      = ~pha;
               lsb_first = ~lsb;
               clk_div   = div + 8'd3;
            end
         end
      end

      check_eq("timeout", done, 1);
      check_eq("mosi_word", mosi_w, data);
      check_eq("rx_data", got_rx, miso_w);
      check_eq("rx_pulses", npulse, 1);
      check_eq("rx_cycle", pulse_cyc, (2 * DW + 2) * h);
      check_eq("cs_low", cs_low, (2 * DW + 2) * h);
      check_eq("sclk_edges", nedge, 2 * DW);
      check_eq("frame_len", len, (2 * DW + 3) * h);
      check_eq("cs_gap", gap, h + 1);
      check_eq("sclk_idle", first_sclk, pol);
      check_eq("cs_first", first_cs, 0);
      if (!pha) check_eq("first_mosi", first_mosi, lsb ? data[0] : data[DW-1]);
      check_eq("ready_low", ready_bad, 0);
      check_eq("rx_hold", rx_changes, 0);
      check_eq("idle_mosi", mosi0, 0);
   endtask

   initial begin
      areset    = 1'b1;
      tx_valid  = 1'b0;
      tx_data   = '0;
      cpol      = 1'b0;
      cpha      = 1'b0;
      lsb_first = 1'b0;
      clk_div   = '0;
      miso0     = 1'b0;
      repeat (3) @(negedge pclk);
      check_eq("rst_sclk", sclk, 0);
      check_eq("rst_cs", cs, 1);
      check_eq("rst_mosi", mosi0, 0);
      check_eq("rst_rx_valid", rx_valid, 0);
      check_eq("rst_rx_data", rx_data, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_ready", tx_ready, 0);
      areset = 1'b0;
      #1;
      check_eq("ready_after_rst", tx_ready, 1);
      @(negedge pclk);

      run_frame(8'hA5, 1'b0, 1'b0, 1'b0, 8'd1, 8'h3C, 1'b0, 8'h00, 1'b0, 0);
      run_frame(8'h01, 1'b1, 1'b1, 1'b1, 8'd0, 8'h80, 1'b0, 8'h00, 1'b0, 0);
      run_frame(8'h11, 1'b0, 1'b0, 1'b0, 8'd1, 8'h5A, 1'b1, 8'h22, 1'b0, 0);
      run_frame(8'h22, 1'b0, 1'b0, 1'b0, 8'd1, 8'hC6, 1'b0, 8'h00, 1'b0, 0);
      run_frame(8'hC3, 1'b0, 1'b1, 1'b0, 8'd2, 8'h96, 1'b0, 8'h00, 1'b1, 0);
      run_frame(8'hF0, 1'b1, 1'b0, 1'b0, 8'd1, 8'hAA, 1'b0, 8'h00, 1'b0, 3);
      run_frame(8'h0F, 1'b1, 1'b0, 1'b0, 8'd1, 8'h69, 1'b0, 8'h00, 1'b0, 0);

      for (int i = 0; i < 10; i++) begin
         run_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   8'($urandom_range(0, 3)), 8'($urandom), 1'b0, 8'h00, 1'b0, 0);
      end

      run_frame(8'h5C, 1'b0, 1'b0, 1'b1, 8'd255, 8'hE7, 1'b0, 8'h00, 1'b0, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
